// File: rtl/spmm_host_driver.sv
// spmm_host_driver: buffers a dense RHS and a CSR LHS, plays them into SpMM, collects results.
// Optional wait-state watchdog: define SPMM_DRV_TIMEOUT_EN (limit = TIMEOUT cycles).
module spmm_host_driver #(
  parameter int N       = 16,
  parameter int W       = 8,
  parameter int TIMEOUT = 1024,
  localparam int LG     = $clog2(N)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rhs_wr_en,
  input  logic [LG-1:0]            rhs_wr_row,
  input  logic [N-1:0][W-1:0]      rhs_wr_data,
  input  logic                     lhs_wr_en,
  input  logic [LG-1:0]            lhs_wr_beat,
  input  logic [N-1:0][2*LG-1:0]   lhs_wr_ptr,
  input  logic [N-1:0][LG-1:0]     lhs_wr_col,
  input  logic [N-1:0][W-1:0]      lhs_wr_data,
  input  logic [LG-1:0]            res_rd_row,
  output logic [N-1:0][W-1:0]      res_rd_data,
  input  logic                     job_start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  input  logic                     rhs_ready,
  input  logic                     lhs_ready_ns,
  input  logic                     out_ready,
  output logic                     rhs_start,
  output logic                     lhs_start,
  output logic                     out_start,
  output logic                     lhs_ws,
  output logic                     lhs_os,
  output logic [3:0][N-1:0][W-1:0] rhs_data,
  output logic [N-1:0][2*LG-1:0]   lhs_ptr,
  output logic [N-1:0][LG-1:0]     lhs_col,
  output logic [N-1:0][W-1:0]      lhs_data,
  input  logic [3:0][N-1:0][W-1:0] out_data
);

  localparam int Q = N / 4;
  localparam logic [LG-1:0] Q_LAST = LG'(Q - 1);
  localparam logic [LG-1:0] Q_END  = LG'(Q);
  localparam logic [LG-1:0] N_LAST = LG'(N - 1);

  typedef enum logic [2:0] {
    IDLE, SEND_RHS, WAIT_LHS, SEND_LHS, WAIT_OUT, RECV_OUT, FIN
  } state_t;

  state_t        state;
  logic          pending;
  logic [LG-1:0] beat;

  logic [N-1:0][W-1:0]    rhs_mem [N];
  logic [N-1:0][2*LG-1:0] ptr_mem [N];
  logic [N-1:0][LG-1:0]   col_mem [N];
  logic [N-1:0][W-1:0]    dat_mem [N];
  logic [N-1:0][W-1:0]    res_mem [N];

  logic                     rhs_we;
  logic                     lhs_we;
  logic                     cap;
  logic                     expire;
  logic [LG-1:0]            nxt;
  logic [LG-1:0]            rd_row  [4];
  logic [LG-1:0]            cap_row [4];
  logic [3:0][N-1:0][W-1:0] rhs_nxt;

  assign busy   = state != IDLE;
  assign lhs_ws = 1'b0;
  assign lhs_os = 1'b0;
  assign rhs_we = rhs_wr_en && !busy;
  assign lhs_we = lhs_wr_en && !busy;
  assign cap    = reset && state == RECV_OUT && beat != '0;
  assign nxt    = (state == SEND_RHS || state == SEND_LHS)
                ? beat + 1'b1 : '0;

  // next RHS beat rows; a same-cycle loader write bypasses into beat 0
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_row[i]  = LG'(4 * int'(nxt) + i);
      cap_row[i] = LG'(4 * (int'(beat) - 1) + i);
      if (rhs_we && rhs_wr_row == rd_row[i])
        rhs_nxt[i] = rhs_wr_data;
      else
        rhs_nxt[i] = rhs_mem[rd_row[i]];
    end
  end

`ifdef SPMM_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wdog;
  logic          err_q;
  logic          stall;

  assign stall  = (state == WAIT_LHS && !lhs_ready_ns)
               || (state == WAIT_OUT && !out_ready)
               || (state == IDLE && pending && !rhs_ready);
  assign expire = stall && wdog == TW'(TIMEOUT - 1);
  assign err    = err_q;

  // watchdog: counts stalled cycles, restarts whenever the wait ends
  always_ff @(posedge clock) begin
    if (!reset) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else if (expire) begin
      wdog  <= '0;
      err_q <= 1'b1;
    end else if (stall) begin
      wdog  <= wdog + 1'b1;
    end else begin
      wdog  <= '0;
    end
  end
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  // job sequencer with registered start pulses and beat data
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      beat      <= '0;
      done      <= 1'b0;
      rhs_start <= 1'b0;
      lhs_start <= 1'b0;
      out_start <= 1'b0;
      rhs_data  <= '0;
      lhs_ptr   <= '0;
      lhs_col   <= '0;
      lhs_data  <= '0;
    end else begin
      done      <= 1'b0;
      rhs_start <= 1'b0;
      lhs_start <= 1'b0;
      out_start <= 1'b0;
      if (expire) begin
        state   <= IDLE;
        pending <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if ((job_start || pending) && rhs_ready) begin
              state     <= SEND_RHS;
              pending   <= 1'b0;
              beat      <= '0;
              rhs_start <= 1'b1;
              rhs_data  <= rhs_nxt;
            end else if (job_start) begin
              pending <= 1'b1;
            end
          end
          SEND_RHS: begin
            if (beat == Q_LAST) begin
              state    <= WAIT_LHS;
              rhs_data <= '0;
            end else begin
              beat     <= beat + 1'b1;
              rhs_data <= rhs_nxt;
            end
          end
          WAIT_LHS: begin
            if (lhs_ready_ns) begin
              state     <= SEND_LHS;
              beat      <= '0;
              lhs_start <= 1'b1;
              lhs_ptr   <= ptr_mem[nxt];
              lhs_col   <= col_mem[nxt];
              lhs_data  <= dat_mem[nxt];
            end
          end
          SEND_LHS: begin
            if (beat == N_LAST) begin
              state    <= WAIT_OUT;
              lhs_ptr  <= '0;
              lhs_col  <= '0;
              lhs_data <= '0;
            end else begin
              beat     <= beat + 1'b1;
              lhs_ptr  <= ptr_mem[nxt];
              lhs_col  <= col_mem[nxt];
              lhs_data <= dat_mem[nxt];
            end
          end
          WAIT_OUT: begin
            if (out_ready) begin
              state     <= RECV_OUT;
              beat      <= '0;
              out_start <= 1'b1;
            end
          end
          RECV_OUT: begin
            if (beat == Q_END) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              beat <= beat + 1'b1;
            end
          end
          FIN: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // loader writes (idle only) and capture of registered SpMM output beats
  always_ff @(posedge clock) begin
    if (rhs_we)
      rhs_mem[rhs_wr_row] <= rhs_wr_data;
    if (lhs_we) begin
      ptr_mem[lhs_wr_beat] <= lhs_wr_ptr;
      col_mem[lhs_wr_beat] <= lhs_wr_col;
      dat_mem[lhs_wr_beat] <= lhs_wr_data;
    end
    if (cap)
      for (int i = 0; i < 4; i++)
        res_mem[cap_row[i]] <= out_data[i];
  end

  // registered result read port
  always_ff @(posedge clock) begin
    if (!reset)
      res_rd_data <= '0;
    else
      res_rd_data <= res_mem[res_rd_row];
  end

endmodule

// File: doc/spmm_host_driver.md
# spmm_host_driver

Host-side sequencer that drives the SpMM accelerator's RHS, LHS and output ports. It holds a dense RHS matrix and a CSR LHS stream in local buffers. On a single job command it plays them into SpMM using the rhs_start/lhs_start burst protocol, then collects the 4-row output bursts into a result buffer. The block sits between the system-side loader/reader and one SpMM instance, and is that instance's only initiator.

## Interface
- N, default 16: matrix dimension; N ≥ 4, power of two, multiple of 4
- W, default 8: element width (data_t)
- TIMEOUT, default 1024: watchdog limit in cycles; used only with SPMM_DRV_TIMEOUT_EN
- clock  in  1  sole clock, rising edge
- reset  in  1  reset is synchronous and active-low
- rhs_wr_en / rhs_wr_row  in  1 / lgN  write one RHS row into rhs_mem
- rhs_wr_data  in  N×W  row contents
- lhs_wr_en / lhs_wr_beat  in  1 / lgN  write one LHS beat into lhs_mem
- lhs_wr_ptr / lhs_wr_col / lhs_wr_data  in  N×2lgN / N×lgN / N×W  beat contents
- res_rd_row  in  lgN  result row select
- res_rd_data  out  N×W  registered read of res_mem[res_rd_row]
- job_start  in  1  single-cycle job request
- busy / done / err  out  1  busy = job active; done = 1-cycle completion pulse; err = sticky timeout flag
- rhs_ready, lhs_ready_ns, out_ready  in  1  SpMM status inputs
- rhs_start, lhs_start, out_start  out  1  SpMM burst starts
- lhs_ws, lhs_os  out  1  tied to 0
- rhs_data  out  4×N×W; lhs_ptr, lhs_col, lhs_data  out  N-wide vectors
- out_data  in  4×N×W  SpMM output burst

## Operation
- FSM states: IDLE → SEND_RHS → WAIT_LHS → SEND_LHS → WAIT_OUT → RECV_OUT → FIN → IDLE.
- IDLE → SEND_RHS requires job_start && rhs_ready. With job_start && !rhs_ready, the request is latched (pending) and the FSM leaves IDLE on the first cycle rhs_ready is seen.
- SEND_RHS, N/4 beats, beat counter k = 0..N/4-1:
  - rhs_start = 1 on beat 0 only.
  - rhs_data[i][j] = rhs_mem[4k+i][j].
- WAIT_LHS: wait for lhs_ready_ns = 1.
- SEND_LHS, N beats, b = 0..N-1:
  - lhs_start = 1 on beat 0 only.
  - lhs_ptr/col/data = lhs_mem[b].
- WAIT_OUT: wait for out_ready = 1. Then assert out_start for 1 cycle and enter RECV_OUT.
- RECV_OUT: capture N/4 beats. Beat k writes out_data[i] to res_mem[4k+i].
- FIN: done = 1 for one cycle; return to IDLE.
- busy = 1 in every state except IDLE.
- Buffer writes:
  - Accepted only while busy = 0; ignored while busy = 1.
  - A write and a job_start in the same cycle: the write lands first, and the job uses the new data.
- job_start while busy = 1 is ignored (not queued).
- rhs_data/lhs_* outputs are driven 0 outside their send states.

## Timing
- Reset values: busy, done, err, all *_start, lhs_ws, lhs_os, rhs_data, lhs_*, res_rd_data = 0; FSM = IDLE; pending cleared.
- rhs_mem, lhs_mem and res_mem are not cleared by reset.
- Start pulses and beat data are registered outputs. Beat 0 appears the cycle after the FSM decision edge.
- Output capture: SpMM registers out_data, so beat k is sampled 1 cycle after enable cycle k. Capture therefore occurs on cycles t0+1 … t0+N/4, where t0 is the out_start cycle.
- Fixed overhead: 1 cycle per wait-state exit.
- Minimum job length = N/4 + N + N/4 + 4 cycles plus SpMM compute latency (N=16: 28 + latency).
- res_rd_data latency: 1 cycle.
- Reset mid-job: FSM returns to IDLE on the next edge and all starts drop. A partially written res_mem is left as is.

## Configuration
- SPMM_DRV_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in WAIT_LHS or WAIT_OUT, or pending in IDLE.
  - When the count reaches TIMEOUT: err ← 1 (sticky until reset), FSM → IDLE, no done pulse.
  - The counter restarts on every state change.
- SPMM_DRV_TIMEOUT_EN undefined: no watchdog; the FSM waits indefinitely; err is tied to 0.

## Test plan
- Identity round trip, N=16: rhs_mem = I, lhs = dense row r = [r+1…], then job_start → res_mem equals the LHS values. done pulses once; busy is high for ≥ 28 cycles.
- Burst format: job_start with rhs_ready = 1 → rhs_start is a 1-cycle pulse; beat k rhs_data[2][5] = rhs_mem[4k+2][5]; lhs_start rises only after lhs_ready_ns.
- Deferred start: job_start while rhs_ready = 0, then rhs_ready = 1 ten cycles later → SEND_RHS begins the next cycle and the job completes normally.
- Write blocking: rhs_wr_en during SEND_LHS with row 3 = all 0xFF → rhs_mem unchanged and the next job's result is unaffected.
- Reset mid-job: reset low during SEND_LHS beat 5 → all outputs 0 next cycle and busy = 0; a following job completes correctly.
- Timeout (macro on, TIMEOUT = 50): out_ready held at 0 → err = 1 after 50 cycles in WAIT_OUT, busy = 0, no done pulse.
